ray_hit_accumulator: RTL and testbench
======================================

RAY_HIT_ACCUMULATOR -- requirements
Module: ray_hit_accumulator

Interface
REQ-001 SHALL have parameter WIDTH, default 4, hit lanes per input beat (power of two, 1..16).
REQ-002 SHALL have parameter TAG_WIDTH, default 4, ray tag width.
REQ-003 SHALL have port clk  input  1  the single clock; all state changes on its rising edge.
REQ-004 SHALL have port reset  input  1  asynchronous, active-high reset.
REQ-005 SHALL have port in_valid  input  1  beat valid.
REQ-006 SHALL have port in_ready  output  1  beat accepted when in_valid and in_ready are both high.
REQ-007 SHALL have port in_first  input  1  first beat of a ray.
REQ-008 SHALL have port in_last  input  1  last beat of a ray; first and last may both be high.
REQ-009 SHALL have port in_mode  input  1  0 = closest hit, 1 = any hit; sampled on the first beat only.
REQ-010 SHALL have port in_tag  input  TAG_WIDTH  ray tag; sampled on the first beat only.
REQ-011 SHALL have port in_hit  input  HitData[WIDTH]  per-lane primitive test results.
REQ-012 SHALL have port out_valid  output  1  result valid.
REQ-013 SHALL have port out_ready  input  1  result consumed when out_valid and out_ready are both high.
REQ-014 SHALL have port out_hit  output  HitData  final hit.
REQ-015 SHALL have port out_tag  output  TAG_WIDTH  tag of the ray.
REQ-016 SHALL have port out_beats  output  8  accepted beats for the ray, saturating at 255.
REQ-017 SHALL have port out_err  output  1  a protocol violation occurred during this ray.

Function
REQ-018 SHALL reduce each beat combinationally to one HitData: only lanes with bHit=1 take part; the smallest T wins, compared signed as Fixed; a tie goes to the lowest lane; with no hitting lane the result is bHit=0, T=FixedInf.
REQ-019 SHALL implement the states IDLE, ACCUM, SKIP and DONE.
REQ-020 IDLE: in_ready=1; an accepted beat with in_first=1 loads the accumulator, tag, mode and beats=1; the next state is DONE if in_last=1, SKIP if mode=1 and the beat hit, otherwise ACCUM.
REQ-021 IDLE: an accepted beat with in_first=0 SHALL be discarded and SHALL set a pending-error flag that is reported on the next result.
REQ-022 ACCUM: in_ready=1; per accepted beat, the accumulator is replaced only if the beat hit and (acc.bHit=0 or beat.T < acc.T strictly), so earlier beats win ties; beats increments.
REQ-023 ACCUM: in mode 1, a hitting beat that is not last SHALL move the state to SKIP; a beat with in_last=1 SHALL move the state to DONE.
REQ-024 ACCUM: an accepted beat with in_first=1 SHALL set err and restart accumulation from that beat, including new tag and mode.
REQ-025 SKIP: in_ready=1; accepted beats are counted but their hit data is ignored; in_last=1 moves the state to DONE.
REQ-026 DONE: out_valid=1 and in_ready=0; outputs hold stable until out_ready=1, then the state returns to IDLE and err clears.
REQ-027 Latency: out_valid SHALL rise on the first clock edge after the last beat is accepted; with out_ready held at 1, a ray of N beats SHALL occupy N+1 cycles.
REQ-028 In mode 1, out_hit SHALL be the first hit encountered (earliest beat, lowest lane), not the closest.
REQ-029 While in DONE, in_valid SHALL be ignored and input data SHALL NOT affect the outputs.

Reset
REQ-030 When reset is asserted, the block SHALL go to IDLE immediately, regardless of the clock.
REQ-031 Reset SHALL force out_valid=0, out_hit.bHit=0, out_hit.T=FixedInf, out_tag=0, out_beats=0, out_err=0 and pending-error=0.
REQ-032 Reset mid-ray SHALL discard the partial result; no out_valid for that ray SHALL ever appear.

Structure
REQ-033 HitData, Fixed, FixedInf and the hit-mode enumeration SHALL come from the shared types package; the state enum SHALL stay local to the block.
REQ-034 The per-beat lane reduction SHALL be a sub-module named hit_min_tree, a log2(WIDTH)-deep comparator tree parameterised by WIDTH.

Verification
REQ-035 One beat, first=last, mode 0, lanes T={5,2,2,9}, all hitting -> after 1 cycle out_hit = lane 1 (T=2), out_beats=1, out_err=0.
REQ-036 Three beats, mode 0, best T {7, 3, 3} in beats 0/1/2 -> out_hit from beat 1, out_beats=3; out_ready low for 4 cycles -> outputs stable and in_ready=0.
REQ-037 Mode 1, four beats, hit only in beat 1 lane 2 -> state goes to SKIP after beat 1, out_hit = that lane, out_beats=4.
REQ-038 Mode 0, no lane hits in 2 beats -> out_hit.bHit=0, T=FixedInf; a stray beat with first=0 in IDLE before the next ray -> that ray reports out_err=1.
REQ-039 Reset asserted between clock edges during beat 2 of 3 -> outputs go to reset values at once; a following ray of 1 beat produces a correct result, out_err=0.

Source files
------------

// File: rtl/ray_hit_accumulator_pkg.sv
// Shared ray-tracing hit types: fixed-point distance, hit record and hit-mode encoding.
package ray_hit_accumulator_pkg;

    typedef logic signed [15:0] Fixed;

    localparam Fixed FixedInf = 16'sh7fff;

    typedef enum logic {
        HitClosest = 1'b0,
        HitAny     = 1'b1
    } hit_mode_e;

    typedef struct packed {
        logic       bHit;
        Fixed       T;
        logic [7:0] prim;
    } HitData;

    localparam HitData HitNone = '{bHit: 1'b0, T: FixedInf, prim: 8'd0};

    // True when cand should replace cur; a tie keeps cur.
    function automatic logic hit_closer(input HitData cur, input HitData cand);
        return cand.bHit && (!cur.bHit || ($signed(cand.T) < $signed(cur.T)));
    endfunction

endpackage

// File: rtl/ray_hit_accumulator_hit_min_tree.sv
// Combinational closest-hit reduction over WIDTH lanes as a log2(WIDTH)-deep comparator tree.
module hit_min_tree
    import ray_hit_accumulator_pkg::*;
#(
    parameter int unsigned WIDTH = 4
) (
    input  HitData lanes [WIDTH],
    output HitData best
);

    localparam int unsigned Depth = $clog2(WIDTH);

    // Left operand always covers the lower lanes, so ties resolve to the lowest lane.
    for (genvar l = 0; l <= Depth; l++) begin : g_lvl
        HitData v [WIDTH >> l];
        if (l == 0) begin : g_leaf
            for (genvar i = 0; i < WIDTH; i++) begin : g_lane
                assign v[i] = lanes[i].bHit ? lanes[i] : HitNone;
            end
        end else begin : g_cmp
            for (genvar i = 0; i < (WIDTH >> l); i++) begin : g_pair
                assign v[i] = hit_closer(g_lvl[l-1].v[2*i], g_lvl[l-1].v[2*i+1]) ?
                              g_lvl[l-1].v[2*i+1] : g_lvl[l-1].v[2*i];
            end
        end
    end

    assign best = g_lvl[Depth].v[0];

endmodule

// File: rtl/ray_hit_accumulator.sv
// Accumulates per-beat hit results of one ray into a closest or first hit, with beat count and
// protocol-error reporting.
module ray_hit_accumulator
    import ray_hit_accumulator_pkg::*;
#(
    parameter int unsigned WIDTH     = 4,
    parameter int unsigned TAG_WIDTH = 4
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 in_valid,
    output logic                 in_ready,
    input  logic                 in_first,
    input  logic                 in_last,
    input  logic                 in_mode,
    input  logic [TAG_WIDTH-1:0] in_tag,
    input  HitData               in_hit [WIDTH],
    output logic                 out_valid,
    input  logic                 out_ready,
    output HitData               out_hit,
    output logic [TAG_WIDTH-1:0] out_tag,
    output logic [7:0]           out_beats,
    output logic                 out_err
);

    localparam logic [1:0] StIdle  = 2'd0;
    localparam logic [1:0] StAccum = 2'd1;
    localparam logic [1:0] StSkip  = 2'd2;
    localparam logic [1:0] StDone  = 2'd3;

    logic [1:0]           state_q, state_d;
    HitData               acc_q, acc_d;
    logic [TAG_WIDTH-1:0] tag_q, tag_d;
    hit_mode_e            mode_q, mode_d;
    logic [7:0]           beats_q, beats_d;
    logic                 err_q, err_d;
    logic                 pend_q, pend_d;

    HitData    beat_best;
    logic      accept;
    logic      start;
    logic [7:0] beats_inc;
    hit_mode_e in_mode_e;

    hit_min_tree #(
        .WIDTH(WIDTH)
    ) u_tree (
        .lanes(in_hit),
        .best (beat_best)
    );

    assign in_ready  = (state_q != StDone);
    assign accept    = in_valid && in_ready;
    assign beats_inc = (beats_q == 8'hff) ? 8'hff : beats_q + 8'd1;
    assign in_mode_e = hit_mode_e'(in_mode);

    always_comb begin
        state_d = state_q;
        acc_d   = acc_q;
        tag_d   = tag_q;
        mode_d  = mode_q;
        beats_d = beats_q;
        err_d   = err_q;
        pend_d  = pend_q;
        start   = 1'b0;
        case (state_q)
            StIdle: begin
                if (accept) begin
                    if (in_first) start = 1'b1;
                    else          pend_d = 1'b1;
                end
            end
            StAccum, StSkip: begin
                if (accept) begin
                    if (in_first) begin
                        // A new ray arriving mid-ray is a violation; it replaces the partial one.
                        start = 1'b1;
                        err_d = 1'b1;
                    end else begin
                        beats_d = beats_inc;
                        if (state_q == StAccum && hit_closer(acc_q, beat_best)) acc_d = beat_best;
                        if (in_last) begin
                            state_d = StDone;
                        end else if (state_q == StAccum && mode_q == HitAny && beat_best.bHit) begin
                            state_d = StSkip;
                        end
                    end
                end
            end
            default: begin
                if (out_ready) begin
                    state_d = StIdle;
                    err_d   = 1'b0;
                end
            end
        endcase
        if (start) begin
            acc_d   = beat_best;
            tag_d   = in_tag;
            mode_d  = in_mode_e;
            beats_d = 8'd1;
            if (state_q == StIdle) begin
                err_d  = pend_q;
                pend_d = 1'b0;
            end
            if (in_last)                              state_d = StDone;
            else if (in_mode_e == HitAny && beat_best.bHit) state_d = StSkip;
            else                                      state_d = StAccum;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q <= StIdle;
            acc_q   <= HitNone;
            tag_q   <= '0;
            mode_q  <= HitClosest;
            beats_q <= 8'd0;
            err_q   <= 1'b0;
            pend_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            acc_q   <= acc_d;
            tag_q   <= tag_d;
            mode_q  <= mode_d;
            beats_q <= beats_d;
            err_q   <= err_d;
            pend_q  <= pend_d;
        end
    end

    assign out_valid = (state_q == StDone);
    assign out_hit   = acc_q;
    assign out_tag   = tag_q;
    assign out_beats = beats_q;
    assign out_err   = err_q;

endmodule

// File: tb/tb_ray_hit_accumulator.sv
// Directed self-checking bench for ray_hit_accumulator with hand-computed expectations.
module tb_ray_hit_accumulator;
    import ray_hit_accumulator_pkg::*;

    logic       clk;
    logic       reset;
    logic       in_valid;
    logic       in_ready;
    logic       in_first;
    logic       in_last;
    logic       in_mode;
    logic [3:0] in_tag;
    HitData     in_hit [4];
    logic       out_valid;
    logic       out_ready;
    HitData     out_hit;
    logic [3:0] out_tag;
    logic [7:0] out_beats;
    logic       out_err;

    int passed = 0;
    int total  = 0;

    ray_hit_accumulator #(
        .WIDTH    (4),
        .TAG_WIDTH(4)
    ) dut (
        .clk      (clk),
        .reset    (reset),
        .in_valid (in_valid),
        .in_ready (in_ready),
        .in_first (in_first),
        .in_last  (in_last),
        .in_mode  (in_mode),
        .in_tag   (in_tag),
        .in_hit   (in_hit),
        .out_valid(out_valid),
        .out_ready(out_ready),
        .out_hit  (out_hit),
        .out_tag  (out_tag),
        .out_beats(out_beats),
        .out_err  (out_err)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic set_inputs(input logic first, input logic last, input logic mode,
                              input logic [3:0] tag, input logic [3:0] mask,
                              input int t0, input int t1, input int t2, input int t3,
                              input logic [7:0] pbase);
        int ts [4];
        ts = '{t0, t1, t2, t3};
        in_valid = 1'b1;
        in_first = first;
        in_last  = last;
        in_mode  = mode;
        in_tag   = tag;
        for (int i = 0; i < 4; i++) begin
            in_hit[i].bHit = mask[i];
            in_hit[i].T    = 16'(ts[i]);
            in_hit[i].prim = pbase + 8'(i);
        end
    endtask

    task automatic beat(input logic first, input logic last, input logic mode,
                        input logic [3:0] tag, input logic [3:0] mask,
                        input int t0, input int t1, input int t2, input int t3,
                        input logic [7:0] pbase);
        @(negedge clk);
        set_inputs(first, last, mode, tag, mask, t0, t1, t2, t3, pbase);
        @(posedge clk);
    endtask

    task automatic test_reset();
        in_valid = 1'b0; in_first = 1'b0; in_last = 1'b0; in_mode = 1'b0; in_tag = 4'd0;
        out_ready = 1'b1;
        for (int i = 0; i < 4; i++) in_hit[i] = '{bHit: 1'b0, T: 16'sd0, prim: 8'd0};
        reset = 1'b0;
        #1 reset = 1'b1;
        #1;
        total++; if (out_valid !== 1'b0) $display("FAIL reset_valid: got %b want 0", out_valid); else passed++;
        total++; if (in_ready !== 1'b1) $display("FAIL reset_ready: got %b want 1", in_ready); else passed++;
        total++; if (out_hit.bHit !== 1'b0) $display("FAIL reset_bhit: got %b want 0", out_hit.bHit); else passed++;
        total++; if (out_hit.T !== 16'h7fff) $display("FAIL reset_t: got %h want 7fff", out_hit.T); else passed++;
        total++; if (out_tag !== 4'd0) $display("FAIL reset_tag: got %0d want 0", out_tag); else passed++;
        total++; if (out_beats !== 8'd0) $display("FAIL reset_beats: got %0d want 0", out_beats); else passed++;
        total++; if (out_err !== 1'b0) $display("FAIL reset_err: got %b want 0", out_err); else passed++;
        @(negedge clk);
        reset = 1'b0;
    endtask

    task automatic test_single_beat();
        beat(1'b1, 1'b1, 1'b0, 4'd5, 4'b1111, 5, 2, 2, 9, 8'h00);
        @(negedge clk);
        in_valid = 1'b0;
        total++; if (out_valid !== 1'b1) $display("FAIL single_valid: got %b want 1", out_valid); else passed++;
        total++; if (out_hit.prim !== 8'h01) $display("FAIL single_lane: got %h want 01", out_hit.prim); else passed++;
        total++; if (out_hit.T !== 16'd2) $display("FAIL single_t: got %0d want 2", $signed(out_hit.T)); else passed++;
        total++; if (out_tag !== 4'd5) $display("FAIL single_tag: got %0d want 5", out_tag); else passed++;
        total++; if (out_beats !== 8'd1) $display("FAIL single_beats: got %0d want 1", out_beats); else passed++;
        total++; if (out_err !== 1'b0) $display("FAIL single_err: got %b want 0", out_err); else passed++;
        @(negedge clk);
        total++; if (out_valid !== 1'b0) $display("FAIL single_release: got %b want 0", out_valid); else passed++;
        total++; if (in_ready !== 1'b1) $display("FAIL single_idle_ready: got %b want 1", in_ready); else passed++;
    endtask

    task automatic test_hold();
        out_ready = 1'b0;
        beat(1'b1, 1'b0, 1'b0, 4'd4, 4'b1111, 9, 7, 8, 10, 8'h00);
        beat(1'b0, 1'b0, 1'b0, 4'd0, 4'b1111, 3, 5, 6, 4, 8'h10);
        beat(1'b0, 1'b1, 1'b0, 4'd0, 4'b1111, 8, 3, 9, 9, 8'h20);
        for (int c = 0; c < 4; c++) begin
            @(negedge clk);
            // Junk on the input side while the result waits must change nothing.
            set_inputs(1'b1, 1'b1, 1'b1, 4'd15, 4'b1111, -100, -100, -100, -100, 8'hee);
            total++; if (out_valid !== 1'b1) $display("FAIL hold_valid c%0d: got %b want 1", c, out_valid); else passed++;
            total++; if (in_ready !== 1'b0) $display("FAIL hold_ready c%0d: got %b want 0", c, in_ready); else passed++;
            total++; if (out_hit.prim !== 8'h10) $display("FAIL hold_prim c%0d: got %h want 10", c, out_hit.prim); else passed++;
            total++; if (out_hit.T !== 16'd3) $display("FAIL hold_t c%0d: got %0d want 3", c, $signed(out_hit.T)); else passed++;
            total++; if (out_beats !== 8'd3) $display("FAIL hold_beats c%0d: got %0d want 3", c, out_beats); else passed++;
            total++; if (out_tag !== 4'd4) $display("FAIL hold_tag c%0d: got %0d want 4", c, out_tag); else passed++;
        end
        @(negedge clk);
        in_valid = 1'b0;
        out_ready = 1'b1;
        @(negedge clk);
        total++; if (out_valid !== 1'b0) $display("FAIL hold_release: got %b want 0", out_valid); else passed++;
    endtask

    task automatic test_any_hit();
        beat(1'b1, 1'b0, 1'b1, 4'd10, 4'b0000, 1, 1, 1, 1, 8'h00);
        beat(1'b0, 1'b0, 1'b0, 4'd0, 4'b0100, 1, 1, 20, 1, 8'h10);
        beat(1'b0, 1'b0, 1'b0, 4'd0, 4'b1111, 1, 1, 1, 1, 8'h20);
        beat(1'b0, 1'b1, 1'b0, 4'd0, 4'b1111, 0, 0, 0, 0, 8'h30);
        @(negedge clk);
        in_valid = 1'b0;
        total++; if (out_valid !== 1'b1) $display("FAIL any_valid: got %b want 1", out_valid); else passed++;
        total++; if (out_hit.prim !== 8'h12) $display("FAIL any_prim: got %h want 12", out_hit.prim); else passed++;
        total++; if (out_hit.T !== 16'd20) $display("FAIL any_t: got %0d want 20", $signed(out_hit.T)); else passed++;
        total++; if (out_beats !== 8'd4) $display("FAIL any_beats: got %0d want 4", out_beats); else passed++;
        total++; if (out_tag !== 4'd10) $display("FAIL any_tag: got %0d want 10", out_tag); else passed++;
    endtask

    task automatic test_no_hit_and_stray();
        beat(1'b1, 1'b0, 1'b0, 4'd6, 4'b0000, 1, 2, 3, 4, 8'h00);
        beat(1'b0, 1'b1, 1'b0, 4'd0, 4'b0000, 1, 2, 3, 4, 8'h10);
        @(negedge clk);
        in_valid = 1'b0;
        total++; if (out_hit.bHit !== 1'b0) $display("FAIL nohit_bhit: got %b want 0", out_hit.bHit); else passed++;
        total++; if (out_hit.T !== 16'h7fff) $display("FAIL nohit_t: got %h want 7fff", out_hit.T); else passed++;
        total++; if (out_beats !== 8'd2) $display("FAIL nohit_beats: got %0d want 2", out_beats); else passed++;
        total++; if (out_err !== 1'b0) $display("FAIL nohit_err: got %b want 0", out_err); else passed++;
        beat(1'b0, 1'b1, 1'b0, 4'd3, 4'b1111, 1, 1, 1, 1, 8'hf0);
        beat(1'b1, 1'b1, 1'b0, 4'd9, 4'b1111, 4, -3, 7, -1, 8'h40);
        @(negedge clk);
        in_valid = 1'b0;
        total++; if (out_err !== 1'b1) $display("FAIL stray_err: got %b want 1", out_err); else passed++;
        total++; if (out_hit.T !== 16'hfffd) $display("FAIL stray_t: got %0d want -3", $signed(out_hit.T)); else passed++;
        total++; if (out_hit.prim !== 8'h41) $display("FAIL stray_prim: got %h want 41", out_hit.prim); else passed++;
        total++; if (out_tag !== 4'd9) $display("FAIL stray_tag: got %0d want 9", out_tag); else passed++;
        total++; if (out_beats !== 8'd1) $display("FAIL stray_beats: got %0d want 1", out_beats); else passed++;
    endtask

    task automatic test_back_to_back();
        beat(1'b1, 1'b0, 1'b0, 4'd1, 4'b0001, 2, 9, 9, 9, 8'h60);
        beat(1'b1, 1'b1, 1'b0, 4'd2, 4'b0010, 9, 8, 9, 9, 8'h70);
        @(negedge clk);
        in_valid = 1'b0;
        total++; if (out_err !== 1'b1) $display("FAIL restart_err: got %b want 1", out_err); else passed++;
        total++; if (out_tag !== 4'd2) $display("FAIL restart_tag: got %0d want 2", out_tag); else passed++;
        total++; if (out_beats !== 8'd1) $display("FAIL restart_beats: got %0d want 1", out_beats); else passed++;
        total++; if (out_hit.prim !== 8'h71) $display("FAIL restart_prim: got %h want 71", out_hit.prim); else passed++;
        beat(1'b1, 1'b1, 1'b0, 4'd3, 4'b0001, 5, 9, 9, 9, 8'h80);
        @(negedge clk);
        in_valid = 1'b0;
        total++; if (out_err !== 1'b0) $display("FAIL b2b_err: got %b want 0", out_err); else passed++;
        total++; if (out_hit.prim !== 8'h80) $display("FAIL b2b_prim: got %h want 80", out_hit.prim); else passed++;
    endtask

    task automatic test_saturation();
        beat(1'b1, 1'b0, 1'b0, 4'd8, 4'b0001, 50, 0, 0, 0, 8'h00);
        for (int i = 0; i < 299; i++) beat(1'b0, 1'b0, 1'b0, 4'd0, 4'b0000, 0, 0, 0, 0, 8'h00);
        beat(1'b0, 1'b1, 1'b0, 4'd0, 4'b0000, 0, 0, 0, 0, 8'h00);
        @(negedge clk);
        in_valid = 1'b0;
        total++; if (out_valid !== 1'b1) $display("FAIL sat_valid: got %b want 1", out_valid); else passed++;
        total++; if (out_beats !== 8'd255) $display("FAIL sat_beats: got %0d want 255", out_beats); else passed++;
        total++; if (out_hit.T !== 16'd50) $display("FAIL sat_t: got %0d want 50", $signed(out_hit.T)); else passed++;
    endtask

    task automatic test_mid_reset();
        beat(1'b1, 1'b0, 1'b0, 4'd3, 4'b0001, 10, 0, 0, 0, 8'h90);
        beat(1'b0, 1'b0, 1'b0, 4'd0, 4'b0001, 6, 0, 0, 0, 8'ha0);
        @(negedge clk);
        set_inputs(1'b0, 1'b1, 1'b0, 4'd0, 4'b0001, 4, 0, 0, 0, 8'hb0);
        #2 reset = 1'b1;
        #1;
        total++; if (out_valid !== 1'b0) $display("FAIL mreset_valid: got %b want 0", out_valid); else passed++;
        total++; if (out_beats !== 8'd0) $display("FAIL mreset_beats: got %0d want 0", out_beats); else passed++;
        total++; if (out_tag !== 4'd0) $display("FAIL mreset_tag: got %0d want 0", out_tag); else passed++;
        total++; if (out_hit.bHit !== 1'b0) $display("FAIL mreset_bhit: got %b want 0", out_hit.bHit); else passed++;
        total++; if (out_hit.T !== 16'h7fff) $display("FAIL mreset_t: got %h want 7fff", out_hit.T); else passed++;
        in_valid = 1'b0;
        @(negedge clk);
        reset = 1'b0;
        for (int c = 0; c < 3; c++) begin
            @(negedge clk);
            total++; if (out_valid !== 1'b0) $display("FAIL mreset_ghost c%0d: got %b want 0", c, out_valid); else passed++;
        end
        beat(1'b1, 1'b1, 1'b0, 4'd7, 4'b1000, 0, 0, 0, 11, 8'h50);
        @(negedge clk);
        in_valid = 1'b0;
        total++; if (out_valid !== 1'b1) $display("FAIL post_valid: got %b want 1", out_valid); else passed++;
        total++; if (out_hit.prim !== 8'h53) $display("FAIL post_prim: got %h want 53", out_hit.prim); else passed++;
        total++; if (out_hit.T !== 16'd11) $display("FAIL post_t: got %0d want 11", $signed(out_hit.T)); else passed++;
        total++; if (out_tag !== 4'd7) $display("FAIL post_tag: got %0d want 7", out_tag); else passed++;
        total++; if (out_beats !== 8'd1) $display("FAIL post_beats: got %0d want 1", out_beats); else passed++;
        total++; if (out_err !== 1'b0) $display("FAIL post_err: got %b want 0", out_err); else passed++;
    endtask

    initial begin
        test_reset();
        test_single_beat();
        test_hold();
        test_any_hit();
        test_no_hit_and_stray();
        test_back_to_back();
        test_saturation();
        test_mid_reset();
        repeat (2) @(negedge clk);
        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
